alu_stage: RTL and testbench

// Execute stage directly downstream of register_bank. Latches out_rx_data/out_ry_data plus opcode on a

---
 rtl/alu_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stage.sv
// rtl/alu_stage.sv - execute-stage ALU: latches operands on start, returns result, {Z,N,C,V} and write-back
// Define ALU_MUL_EN to make opcode 11 an 8-step iterative shift-add multiply; otherwise it is reserved.
module alu_stage #(
   parameter int DATA_WIDTH = 8,
   parameter int SEL_WIDTH  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_start,
   input  logic [3:0]            in_opcode,
   input  logic [DATA_WIDTH-1:0] in_rx_data,
   input  logic [DATA_WIDTH-1:0] in_ry_data,
   input  logic [SEL_WIDTH-1:0]  in_rx_selector,
   output logic                  out_busy,
   output logic                  out_done,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_wb_en,
   output logic [SEL_WIDTH-1:0]  out_wb_selector,
   output logic [3:0]            out_flags
);

   localparam int W = DATA_WIDTH;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_ADC = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_SBB = 4'd3;
   localparam logic [3:0] OP_AND = 4'd4;
   localparam logic [3:0] OP_OR  = 4'd5;
   localparam logic [3:0] OP_XOR = 4'd6;
   localparam logic [3:0] OP_NOT = 4'd7;
   localparam logic [3:0] OP_SHL = 4'd8;
   localparam logic [3:0] OP_SHR = 4'd9;
   localparam logic [3:0] OP_CMP = 4'd10;
   localparam logic [3:0] OP_MOV = 4'd12;

`ifdef ALU_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd11;
   localparam int CW = $clog2(W);
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC} state_t;
`endif

   state_t state, state_nxt;

   logic [3:0]   op_q;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic         cin_q;
   logic         accept;

   logic [W:0]   sum_full;
   logic [W:0]   diff_full;
   logic         add_cin;
   logic         sub_cin;
   logic [W-1:0] alu_res;
   logic         alu_c;
   logic         alu_v;
   logic         alu_wr;
   logic         alu_wb;
   logic         alu_upd;
   logic [3:0]   alu_flags;

`ifdef ALU_MUL_EN
   logic [2*W-1:0] mul_acc;
   logic [2*W-1:0] mul_mcand;
   logic [2*W-1:0] mul_acc_nxt;
   logic [W-1:0]   mul_mplier;
   logic [CW-1:0]  mul_cnt;
   logic           mul_last;
   logic           mul_hi_nz;

   assign mul_acc_nxt = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
   assign mul_last    = (mul_cnt == CW'(W - 1));
   assign mul_hi_nz   = (mul_acc_nxt[2*W-1:W] != '0);
`endif

   assign accept   = in_start && (state == ST_IDLE);
   assign out_busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (in_start) begin
`ifdef ALU_MUL_EN
               if (in_opcode == OP_MUL) state_nxt = ST_MUL;
               else                     state_nxt = ST_EXEC;
`else
               state_nxt = ST_EXEC;
`endif
            end
         end
         ST_EXEC: state_nxt = ST_IDLE;
`ifdef ALU_MUL_EN
         ST_MUL:  if (mul_last) state_nxt = ST_IDLE;
`endif
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Carry-in comes from the C flag captured at accept, not the live flag.
   always_comb begin
      add_cin   = (op_q == OP_ADC) ? cin_q : 1'b0;
      sub_cin   = (op_q == OP_SBB) ? cin_q : 1'b0;
      sum_full  = {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, add_cin};
      diff_full = {1'b0, a_q} - {1'b0, b_q} - {{W{1'b0}}, sub_cin};
      alu_res   = a_q;
      alu_c     = 1'b0;
      alu_v     = 1'b0;
      alu_wr    = 1'b0;
      alu_wb    = 1'b0;
      alu_upd   = 1'b0;
      case (op_q)
         OP_ADD, OP_ADC: begin
            alu_res = sum_full[W-1:0];
            alu_c   = sum_full[W];
            alu_v   = (a_q[W-1] == b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
            alu_wr  = 1'b1;
            alu_wb  = 1'b1;
            alu_upd = 1'b1;
         end
         OP_SUB, OP_SBB, OP_CMP: begin
            alu_res = diff_full[W-1:0];
            alu_c   = diff_full[W];
            alu_v   = (a_q[W-1] != b_q[W-1]) && (alu_res[W-1] != a_q[W-1]);
            alu_wr  = (op_q != OP_CMP);
            alu_wb  = (op_q != OP_CMP);
            alu_upd = 1'b1;
         end
         OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOV: begin
            case (op_q)
               OP_AND:  alu_res = a_q & b_q;
               OP_OR:   alu_res = a_q | b_q;
               OP_XOR:  alu_res = a_q ^ b_q;
               OP_NOT:  alu_res = ~a_q;
               default: alu_res = b_q;
            endcase
            alu_wr  = 1'b1;
            alu_wb  = 1'b1;
            alu_upd = 1'b1;
         end
         OP_SHL: begin
            alu_res = {a_q[W-2:0], 1'b0};
            alu_c   = a_q[W-1];
            alu_wr  = 1'b1;
            alu_wb  = 1'b1;
            alu_upd = 1'b1;
         end
         OP_SHR: begin
            alu_res = {1'b0, a_q[W-1:1]};
            alu_c   = a_q[0];
            alu_wr  = 1'b1;
            alu_wb  = 1'b1;
            alu_upd = 1'b1;
         end
         default: begin
            alu_res = a_q;
         end
      endcase
      alu_flags = {(alu_res == '0), alu_res[W-1], alu_c, alu_v};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q            <= '0;
         a_q             <= '0;
         b_q             <= '0;
         cin_q           <= 1'b0;
         out_done        <= 1'b0;
         out_wb_en       <= 1'b0;
         out_result      <= '0;
         out_wb_selector <= '0;
         out_flags       <= '0;
`ifdef ALU_MUL_EN
         mul_acc         <= '0;
         mul_mcand       <= '0;
         mul_mplier      <= '0;
         mul_cnt         <= '0;
`endif
      end else begin
         out_done  <= 1'b0;
         out_wb_en <= 1'b0;
         if (accept) begin
            op_q            <= in_opcode;
            a_q             <= in_rx_data;
            b_q             <= in_ry_data;
            cin_q           <= out_flags[1];
            out_wb_selector <= in_rx_selector;
`ifdef ALU_MUL_EN
            mul_acc         <= '0;
            mul_mcand       <= {{W{1'b0}}, in_rx_data};
            mul_mplier      <= in_ry_data;
            mul_cnt         <= '0;
`endif
         end
         if (state == ST_EXEC) begin
            out_done  <= 1'b1;
            out_wb_en <= alu_wb;
            if (alu_wr)  out_result <= alu_res;
            if (alu_upd) out_flags  <= alu_flags;
         end
`ifdef ALU_MUL_EN
         // One partial-product step per cycle; the last step also publishes the low byte.
         if (state == ST_MUL) begin
            mul_acc    <= mul_acc_nxt;
            mul_mcand  <= {mul_mcand[2*W-2:0], 1'b0};
            mul_mplier <= {1'b0, mul_mplier[W-1:1]};
            mul_cnt    <= mul_cnt + 1'b1;
            if (mul_last) begin
               out_done   <= 1'b1;
               out_wb_en  <= 1'b1;
               out_result <= mul_acc_nxt[W-1:0];
               out_flags  <= {(mul_acc_nxt[W-1:0] == '0), mul_acc_nxt[W-1], mul_hi_nz, mul_hi_nz};
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_alu_stage.sv
// tb/tb_alu_stage.sv - directed vector bench for alu_stage
// Covers the ALU_MUL_EN build and the default build (opcode 11 reserved).
module tb_alu_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_start;
   logic [3:0] in_opcode;
   logic [7:0] in_rx_data;
   logic [7:0] in_ry_data;
   logic [2:0] in_rx_selector;
   logic       out_busy;
   logic       out_done;
   logic [7:0] out_result;
   logic       out_wb_en;
   logic [2:0] out_wb_selector;
   logic [3:0] out_flags;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] sel;
      logic [7:0] res;
      logic [3:0] flg;
      logic       wb;
   } vec_t;

   vec_t vecs[$];

   alu_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_start        (in_start),
      .in_opcode       (in_opcode),
      .in_rx_data      (in_rx_data),
      .in_ry_data      (in_ry_data),
      .in_rx_selector  (in_rx_selector),
      .out_busy        (out_busy),
      .out_done        (out_done),
      .out_result      (out_result),
      .out_wb_en       (out_wb_en),
      .out_wb_selector (out_wb_selector),
      .out_flags       (out_flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Called at a negedge with the stage idle; returns at the negedge after the accept edge.
   task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sel);
      in_start       = 1'b1;
      in_opcode      = op;
      in_rx_data     = a;
      in_ry_data     = b;
      in_rx_selector = sel;
      @(negedge clk);
      in_start       = 1'b0;
      in_opcode      = 4'd12;
      in_rx_data     = 8'hA5;
      in_ry_data     = 8'h5A;
      in_rx_selector = ~sel;
   endtask

   task automatic run(input vec_t v, input int exp_lat, input string tag);
      int lat;
      issue(v.op, v.a, v.b, v.sel);
      check({tag, "_busy"}, out_busy, 1);
      lat = 1;
      while (!out_done && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_result"}, out_result, v.res);
      check({tag, "_flags"}, out_flags, v.flg);
      check({tag, "_wb_en"}, out_wb_en, v.wb);
      check({tag, "_wb_sel"}, out_wb_selector, v.sel);
      check({tag, "_busy_at_done"}, out_busy, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, out_done, 0);
      check({tag, "_wb_pulse"}, out_wb_en, 0);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, out_busy, 0);
      check({tag, "_done"}, out_done, 0);
      check({tag, "_result"}, out_result, 0);
      check({tag, "_wb_en"}, out_wb_en, 0);
      check({tag, "_wb_sel"}, out_wb_selector, 0);
      check({tag, "_flags"}, out_flags, 0);
   endtask

   task automatic reset_abort_and_recover(input string tag);
      int pulses;
      rst_n = 1'b0;
      #1;
      check_reset_state(tag);
      @(negedge clk);
      rst_n = 1'b1;
      pulses = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_done || out_wb_en) pulses++;
      end
      check({tag, "_no_done_after_abort"}, pulses, 0);
      run('{4'd0, 8'h02, 8'h03, 3'd2, 8'h05, 4'b0000, 1'b1}, 2, {tag, "_add_after"});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t w;
      rst_n          = 1'b0;
      in_start       = 1'b0;
      in_opcode      = 4'd0;
      in_rx_data     = 8'h00;
      in_ry_data     = 8'h00;
      in_rx_selector = 3'd0;
      repeat (2) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_state("post_reset");

      //             op     A      B      sel   result flags   wb
      vecs.push_back('{4'd0,  8'h7F, 8'h01, 3'd1, 8'h80, 4'b0101, 1'b1});
      vecs.push_back('{4'd0,  8'hFF, 8'h01, 3'd2, 8'h00, 4'b1010, 1'b1});
      vecs.push_back('{4'd1,  8'h00, 8'h00, 3'd3, 8'h01, 4'b0000, 1'b1});
      vecs.push_back('{4'd1,  8'h10, 8'h20, 3'd4, 8'h30, 4'b0000, 1'b1});
      vecs.push_back('{4'd0,  8'h80, 8'h80, 3'd5, 8'h00, 4'b1011, 1'b1});
      vecs.push_back('{4'd2,  8'h05, 8'h03, 3'd6, 8'h02, 4'b0000, 1'b1});
      vecs.push_back('{4'd2,  8'h80, 8'h01, 3'd7, 8'h7F, 4'b0001, 1'b1});
      vecs.push_back('{4'd2,  8'h00, 8'h01, 3'd0, 8'hFF, 4'b0110, 1'b1});
      vecs.push_back('{4'd3,  8'h05, 8'h02, 3'd1, 8'h02, 4'b0000, 1'b1});
      vecs.push_back('{4'd10, 8'h03, 8'h05, 3'd2, 8'h02, 4'b0110, 1'b0});
      vecs.push_back('{4'd3,  8'h00, 8'h00, 3'd3, 8'hFF, 4'b0110, 1'b1});
      vecs.push_back('{4'd4,  8'hF0, 8'h3C, 3'd4, 8'h30, 4'b0000, 1'b1});
      vecs.push_back('{4'd5,  8'h00, 8'h00, 3'd5, 8'h00, 4'b1000, 1'b1});
      vecs.push_back('{4'd6,  8'hAA, 8'hFF, 3'd6, 8'h55, 4'b0000, 1'b1});
      vecs.push_back('{4'd7,  8'h0F, 8'h33, 3'd7, 8'hF0, 4'b0100, 1'b1});
      vecs.push_back('{4'd8,  8'h81, 8'h00, 3'd0, 8'h02, 4'b0010, 1'b1});
      vecs.push_back('{4'd9,  8'h01, 8'h00, 3'd1, 8'h00, 4'b1010, 1'b1});
      vecs.push_back('{4'd12, 8'h11, 8'h9C, 3'd2, 8'h9C, 4'b0100, 1'b1});
      vecs.push_back('{4'd13, 8'h12, 8'h34, 3'd3, 8'h9C, 4'b0100, 1'b0});
      vecs.push_back('{4'd15, 8'h00, 8'h00, 3'd4, 8'h9C, 4'b0100, 1'b0});
      vecs.push_back('{4'd10, 8'h80, 8'h7F, 3'd5, 8'h9C, 4'b0001, 1'b0});
      vecs.push_back('{4'd9,  8'h80, 8'h00, 3'd6, 8'h40, 4'b0000, 1'b1});

      foreach (vecs[i]) run(vecs[i], 2, $sformatf("v%0d", i));

      // Start held during busy is dropped; start during the done cycle is accepted.
      in_start = 1'b1; in_opcode = 4'd0; in_rx_data = 8'h01; in_ry_data = 8'h01;
      in_rx_selector = 3'd1;
      @(negedge clk);
      in_opcode = 4'd12; in_ry_data = 8'h77; in_rx_selector = 3'd5;
      check("b2b_busy1", out_busy, 1);
      @(negedge clk);
      check("b2b_done1", out_done, 1);
      check("b2b_result1", out_result, 8'h02);
      check("b2b_sel1", out_wb_selector, 3'd1);
      @(negedge clk);
      in_start = 1'b0;
      check("b2b_busy2", out_busy, 1);
      check("b2b_done_gap", out_done, 0);
      @(negedge clk);
      check("b2b_done2", out_done, 1);
      check("b2b_result2", out_result, 8'h77);
      check("b2b_flags2", out_flags, 4'b0000);
      check("b2b_sel2", out_wb_selector, 3'd5);
      @(negedge clk);
      check("b2b_idle", out_busy, 0);
      check("b2b_no_extra_done", out_done, 0);

`ifdef ALU_MUL_EN
      issue(4'd11, 8'h10, 8'h11, 3'd3);
      for (int n = 1; n <= 8; n++) begin
         check($sformatf("mul_busy_c%0d", n), out_busy, 1);
         check($sformatf("mul_nodone_c%0d", n), out_done, 0);
         if (n == 3) begin
            in_start = 1'b1; in_opcode = 4'd0; in_rx_data = 8'h01; in_ry_data = 8'h01;
         end
         if (n == 4) in_start = 1'b0;
         @(negedge clk);
      end
      check("mul_done", out_done, 1);
      check("mul_wb_en", out_wb_en, 1);
      check("mul_result", out_result, 8'h10);
      check("mul_flags", out_flags, 4'b0011);
      check("mul_sel", out_wb_selector, 3'd3);
      check("mul_busy_at_done", out_busy, 0);
      @(negedge clk);
      check("mul_ignored_start", out_busy, 0);
      check("mul_done_pulse", out_done, 0);
      run('{4'd11, 8'hFF, 8'hFF, 3'd6, 8'h01, 4'b0011, 1'b1}, 9, "mul_ff_ff");
      run('{4'd11, 8'h00, 8'h05, 3'd7, 8'h00, 4'b1000, 1'b1}, 9, "mul_zero");
      issue(4'd11, 8'h10, 8'h11, 3'd4);
      repeat (3) @(negedge clk);
      check("mul_abort_busy_c4", out_busy, 1);
      reset_abort_and_recover("mul_abort");
`else
      run('{4'd11, 8'h10, 8'h11, 3'd3, 8'h77, 4'b0000, 1'b0}, 2, "mul_reserved");
      run('{4'd7, 8'h00, 8'h00, 3'd6, 8'hFF, 4'b0100, 1'b1}, 2, "not_pre_abort");
      issue(4'd0, 8'h01, 8'h02, 3'd4);
      check("exec_abort_busy", out_busy, 1);
      reset_abort_and_recover("exec_abort");
`endif

      w = '{4'd1, 8'h00, 8'h00, 3'd0, 8'h00, 4'b1000, 1'b1};
      run(w, 2, "adc_after_reset");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
